// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer: FSM state encoding,
// access-kind constants and the word-alignment helper.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Access kind, taken from i_or_d when a request is latched
    localparam logic KIND_INST = 1'b0;
    localparam logic KIND_DATA = 1'b1;

    // Byte-offset bits that must be zero for a legal word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return ((addr_lsb & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/response bus between the sequencer (master) and the unified
// instruction/data memory (slave).
interface mem_access_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  mem_req_valid;
    logic                  mem_req_we;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

endinterface

// File: rtl/mem_access_sequencer_timeout.sv
// Access watchdog: counts cycles spent with a request in flight and flags
// when the count reaches LIMIT. The count saturates at LIMIT.
module mem_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on a new access, otherwise step while enabled
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT_C)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT_C);

endmodule

// File: rtl/mem_access_sequencer.sv
// Turns the multicycle control unit's level strobes into a valid/ready
// memory request, waits for the response, latches IR/MDR and reports
// busy / done / sticky fault back to the control unit.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  i_or_d,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] write_data,
    mem_access_sequencer_if.master mem,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic                  mem_busy,
    output logic                  mem_done,
    output logic                  mem_fault
);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  we_q,    we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  kind_q,  kind_d;
    logic [DATA_WIDTH-1:0] ir_q,    ir_d;
    logic [DATA_WIDTH-1:0] mdr_q,   mdr_d;
    logic                  req_valid_q;
    logic                  done_q;
    logic                  fault_q;

    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  accept_s;
    logic                  in_flight_s;
    logic                  resp_take_s;
    logic                  expired_s;

    assign sel_addr_s  = i_or_d ? alu_out : pc;
    assign in_flight_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign resp_take_s = (state_q == ST_WAIT) && mem.mem_resp_valid;

    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (reset),
        .clear_i   (accept_s),
        .enable_i  (in_flight_s),
        .expired_o (expired_s)
    );

    // Next-state logic; a response in the expiry cycle still completes
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    state_d = ST_FAULT;
                end else if (mem_read ^ mem_write) begin
                    if (is_word_aligned(sel_addr_s[1:0])) begin
                        accept_s = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (expired_s) begin
                    state_d = ST_FAULT;
                end else if (mem.mem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_d = ST_DONE;
                end else if (expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Request latches and IR/MDR next values
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        kind_d  = kind_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        if (accept_s) begin
            addr_d  = sel_addr_s;
            we_d    = mem_write;
            wdata_d = write_data;
            kind_d  = i_or_d;
        end else begin
            addr_d  = addr_q;
            we_d    = we_q;
            wdata_d = wdata_q;
            kind_d  = kind_q;
        end
        if (resp_take_s && !we_q) begin
            if (kind_q == KIND_INST) begin
                ir_d = mem.mem_resp_data;
            end else begin
                mdr_d = mem.mem_resp_data;
            end
        end else begin
            ir_d  = ir_q;
            mdr_d = mdr_q;
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            kind_q      <= KIND_INST;
            ir_q        <= '0;
            mdr_q       <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            kind_q      <= kind_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            req_valid_q <= (state_d == ST_ISSUE);
            done_q      <= (state_d == ST_DONE);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_we    = we_q;
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_wdata = wdata_q;

    assign ir_out    = ir_q;
    assign mdr_out   = mdr_q;
    assign mem_done  = done_q;
    assign mem_fault = fault_q;
    // Combinational so the control unit stalls in the accept cycle itself
    assign mem_busy  = in_flight_s || accept_s;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: stimulus pushes expected
// requests/completions derived from a transaction-level model; a monitor
// compares them whenever the DUT presents a request or a completion.
module tb_mem_access_sequencer;

    localparam int TO = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] ir;
        logic [31:0] mdr;
    } cmp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, i_or_d;
    logic [31:0] pc, alu_out, write_data;
    logic [31:0] ir_out, mdr_out;
    logic        mem_busy, mem_done, mem_fault;

    req_t        exp_req_q[$];
    cmp_t        exp_cmp_q[$];
    logic [31:0] m_ir, m_mdr;
    logic        prev_fault = 1'b0;
    int          checks = 0;
    int          failures = 0;

    mem_access_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    mem_access_sequencer #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .pc         (pc),
        .alu_out    (alu_out),
        .write_data (write_data),
        .mem        (mem_bus),
        .ir_out     (ir_out),
        .mdr_out    (mdr_out),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_fault  (mem_fault)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares requests and completions against the scoreboard
    initial begin
        req_t r;
        cmp_t c;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_bus.mem_req_valid) begin
                    if (exp_req_q.size() == 0) begin
                        check("unexpected_req", mem_bus.mem_req_valid, 1'b0);
                    end else begin
                        r = exp_req_q[0];
                        check("req_we", mem_bus.mem_req_we, r.we);
                        check("req_addr", mem_bus.mem_req_addr, r.addr);
                        check("req_wdata", mem_bus.mem_req_wdata, r.wdata);
                        if (mem_bus.mem_req_ready) void'(exp_req_q.pop_front());
                    end
                end
                if (mem_done || (mem_fault && !prev_fault)) begin
                    if (exp_cmp_q.size() == 0) begin
                        check("unexpected_completion", {mem_done, mem_fault}, 2'b00);
                    end else begin
                        c = exp_cmp_q.pop_front();
                        check("cmp_fault", mem_fault, c.fault);
                        check("cmp_done", mem_done, !c.fault);
                        check("cmp_ir", ir_out, c.ir);
                        check("cmp_mdr", mdr_out, c.mdr);
                    end
                end
            end
            prev_fault = mem_fault;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_valid"}, mem_bus.mem_req_valid, 1'b0);
        check({tag, "_busy"}, mem_busy, 1'b0);
        check({tag, "_done"}, mem_done, 1'b0);
        check({tag, "_fault"}, mem_fault, 1'b0);
        check({tag, "_ir"}, ir_out, 32'h0);
        check({tag, "_mdr"}, mdr_out, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; i_or_d = 1'b0;
        pc = 32'h0; alu_out = 32'h0; write_data = 32'h0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_we", mem_bus.mem_req_we, 1'b0);
        check("rst_req_addr", mem_bus.mem_req_addr, 32'h0);
        check("rst_req_wdata", mem_bus.mem_req_wdata, 32'h0);
        reset = 1'b0;
        exp_req_q.delete();
        exp_cmp_q.delete();
        m_ir = 32'h0;
        m_mdr = 32'h0;
        @(negedge clk);
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
    endtask

    // One access from the control unit; entered and left at posedge+1 in IDLE.
    // The access must finish within TO+1 cycles of ISSUE+WAIT, else it faults.
    task automatic run_access(input logic rd, input logic wr, input logic iod,
                              input logic [31:0] pcv, input logic [31:0] aluv,
                              input logic [31:0] wdv, input logic [31:0] rdata,
                              input int rdly, input int wdly,
                              input bit respond, input bit stray);
        logic [31:0] addr;
        bit          legal, timeout;
        int          last_k;
        addr  = iod ? aluv : pcv;
        legal = (rd ^ wr) && (addr[1:0] == 2'b00);
        mem_read = rd; mem_write = wr; i_or_d = iod;
        pc = pcv; alu_out = aluv; write_data = wdv;
        if (!legal) begin
            exp_cmp_q.push_back(cmp_t'{1'b1, m_ir, m_mdr});
            @(negedge clk);
            check("busy_rejected", mem_busy, 1'b0);
            @(posedge clk); #1;
            // a legal request after the fault must be ignored
            mem_read = 1'b1; mem_write = 1'b0; i_or_d = 1'b0; pc = 32'h40;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("fault_sticky", mem_fault, 1'b1);
                check("fault_busy", mem_busy, 1'b0);
                @(posedge clk); #1;
            end
            do_reset();
            return;
        end
        exp_req_q.push_back(req_t'{wr, addr, wdv});
        timeout = !respond || (rdly + wdly + 2 > TO + 1);
        if (!timeout && rd) begin
            if (iod) m_mdr = rdata;
            else     m_ir  = rdata;
        end
        exp_cmp_q.push_back(cmp_t'{timeout, m_ir, m_mdr});
        @(negedge clk);
        check("busy_accept", mem_busy, 1'b1);
        last_k = timeout ? TO + 2 : rdly + wdly + 2;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            mem_read  = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            i_or_d    = 1'($urandom_range(0, 1));
            pc = $urandom; alu_out = $urandom; write_data = $urandom;
            mem_bus.mem_req_ready  = (k == rdly + 1);
            mem_bus.mem_resp_valid = (respond && (k == rdly + wdly + 2)) ||
                                     (stray && (k <= rdly + 1) && ($urandom_range(0, 1) == 1));
            mem_bus.mem_resp_data  = (k == rdly + wdly + 2) ? rdata : $urandom;
            @(negedge clk);
            if (k <= TO + 1) begin
                check("busy_inflight", mem_busy, 1'b1);
                check("fault_early", mem_fault, 1'b0);
            end else begin
                check("timeout_fault", mem_fault, 1'b1);
                check("timeout_busy", mem_busy, 1'b0);
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        if (timeout) begin
            @(negedge clk);
            check("timeout_sticky", mem_fault, 1'b1);
            do_reset();
            return;
        end
        @(negedge clk);
        check("done_pulse", mem_done, 1'b1);
        check("done_busy", mem_busy, 1'b0);
        @(posedge clk); #1;
        if (stray) begin
            mem_bus.mem_resp_valid = 1'b1;
            mem_bus.mem_resp_data = $urandom;
        end
        @(negedge clk);
        check("done_one_cycle", mem_done, 1'b0);
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
    endtask

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic rd, wr, iod;
        logic [31:0] a_pc, a_alu;
        int sel;
        do_reset();

        // Instruction fetch, minimum latency
        run_access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h00500093, 0, 0, 1'b1, 1'b0);
        // Load with request and response stalls
        run_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h2004, 32'h0, 32'hDEADBEEF, 3, 2, 1'b1, 1'b0);
        // Store: neither IR nor MDR change
        run_access(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hCAFEF00D, 32'h12345678, 1, 1, 1'b1, 1'b1);
        // Read and write together
        run_access(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
        // Misaligned load
        run_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h102, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
        // Memory never answers
        run_access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        // Response exactly at the limit still completes
        run_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h300, 32'h0, 32'hA5A55A5A, 0, TO - 1, 1'b1, 1'b0);
        // One cycle too late
        run_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h304, 32'h0, 32'h11111111, 0, TO, 1'b1, 1'b0);

        // Reset in WAIT, then a stray response
        mem_read = 1'b1; i_or_d = 1'b0; pc = 32'h20; write_data = 32'h0;
        exp_req_q.push_back(req_t'{1'b0, 32'h20, 32'h0});
        @(posedge clk); #1;
        mem_read = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_req_ready = 1'b0;
        @(negedge clk);
        check("busy_before_reset", mem_busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_req_valid", mem_bus.mem_req_valid, 1'b0);
        check("async_rst_busy", mem_busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_req_q.delete();
        exp_cmp_q.delete();
        m_ir = 32'h0; m_mdr = 32'h0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data = 32'hBAD0BAD0;
        @(negedge clk);
        check_idle_outputs("late_resp");
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        check("late_resp_ir_hold", ir_out, 32'h0);
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 32'h0, 32'h00A00113, 1, 0, 1'b1, 1'b0);

        // Randomised accesses
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else begin
                rd = 1'($urandom_range(0, 1));
                wr = !rd;
            end
            iod = 1'($urandom_range(0, 1));
            a_pc = $urandom;
            a_alu = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                a_pc[1:0] = 2'b00;
                a_alu[1:0] = 2'b00;
            end
            run_access(rd, wr, iod, a_pc, a_alu, $urandom, $urandom,
                       $urandom_range(0, 4), $urandom_range(0, 4),
                       ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        check("sb_cmp_drained", exp_cmp_q.size(), 0);
        check("sb_req_drained", exp_req_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
